// File: rtl/multi_latency_control_unit.sv
// -----------------------------------------------------------------------------
// multi_latency_control_unit
//
// Purpose:
//   Issue-side scoreboard at the VRR->EXE boundary for variable-latency vector
//   operations. Up to NUM_SLOTS operations may be in flight at once. Each one
//   owns a single shared writeback cycle, reserved in a shift-register
//   window of depth MAX_LATENCY. The window also carries the operation tag,
//   which is reported when that writeback cycle is reached.
//
// Optional feature (macro LAGARTO_V_IN_ORDER_COMPLETION_EN):
//   Defined   - issue also halts while any older operation would complete
//               after the requesting one, so completion order equals issue
//               order.
//   Undefined - out-of-order completion is allowed. Only writeback collisions
//               and the slot budget stall issue.
//
// Ports:
//   clock_i          in   sole clock, rising edge
//   reset_i          in   synchronous reset, active-high
//   flush_i          in   discard all in-flight operations
//   issue_valid_i    in   an operation requests issue this cycle
//   issue_latency_i  in   latency L of the requesting operation (0..MAX_LATENCY-1)
//   issue_tag_i      in   tag of the requesting operation
//   halt_pipeline_o  out  combinational; issue refused this cycle
//   complete_valid_o out  an operation writes back this cycle (registered)
//   complete_tag_o   out  tag of the completing operation (registered)
//   occupancy_o      out  operations currently outstanding (registered)
//
// Issue handshake:
//   A request is presented by holding issue_valid_i high with its latency and
//   tag. It is taken at the rising edge that ends any cycle in which
//   issue_valid_i=1, halt_pipeline_o=0, flush_i=0 and reset_i=0. While halted,
//   upstream keeps the same request stable and re-presents it. A request
//   present during a flush or reset cycle is dropped without a halt.
//   halt_pipeline_o never depends on itself and is 0 whenever
//   issue_valid_i=0.
// -----------------------------------------------------------------------------
module multi_latency_control_unit #(
    parameter int MAX_LATENCY = 32,
    parameter int NUM_SLOTS   = 4,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           issue_valid_i,
    input  logic [$clog2(MAX_LATENCY)-1:0] issue_latency_i,
    input  logic [TAG_WIDTH-1:0]           issue_tag_i,
    output logic                           halt_pipeline_o,
    output logic                           complete_valid_o,
    output logic [TAG_WIDTH-1:0]           complete_tag_o,
    output logic [$clog2(NUM_SLOTS):0]     occupancy_o
);

    localparam int LW = $clog2(MAX_LATENCY);
    localparam int OW = $clog2(NUM_SLOTS) + 1;
    localparam logic [LW:0]   ONE_L     = (LW+1)'(1);
    localparam logic [OW-1:0] SLOTS_MAX = OW'(NUM_SLOTS);

    // Reservation window: bit i set means some operation writes back i cycles
    // from now. Entry 0 is the writeback happening in the current cycle.
    logic [MAX_LATENCY-1:0] r_res;
    logic [TAG_WIDTH-1:0]   r_tag [MAX_LATENCY];
    logic [OW-1:0]          r_occ;

    logic [MAX_LATENCY:0]   w_res_ext;
    logic [LW:0]            w_lat_p1;
    logic                   w_conflict;
    logic                   w_full;
    logic                   w_block;
    logic                   w_accept;

    // A zero guard bit above the window lets L+1 = MAX_LATENCY index safely and
    // read as "no conflict" without a special case.
    assign w_res_ext = {1'b0, r_res};
    assign w_lat_p1  = {1'b0, issue_latency_i} + ONE_L;

    // The window shifts on the same edge that records the new reservation, so
    // the slot the new operation will occupy is currently sitting at L+1.
    assign w_conflict = w_res_ext[w_lat_p1];

    // A completion this cycle frees its slot for a simultaneous issue.
    assign w_full = (r_occ == SLOTS_MAX) && !r_res[0];

`ifdef LAGARTO_V_IN_ORDER_COMPLETION_EN
    logic [LW:0] w_lat_p2;
    logic        w_older_later;

    // Any reservation strictly above L+1 belongs to an older operation that
    // would write back after this one.
    assign w_lat_p2      = w_lat_p1 + ONE_L;
    assign w_older_later = |(w_res_ext >> w_lat_p2);
    assign w_block       = w_conflict || w_full || w_older_later;
`else
    assign w_block       = w_conflict || w_full;
`endif

    assign halt_pipeline_o = issue_valid_i && w_block && !flush_i && !reset_i;
    assign w_accept        = issue_valid_i && !w_block && !flush_i && !reset_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_res <= '0;
            r_occ <= '0;
            for (int i = 0; i < MAX_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else if (flush_i) begin
            // Tags are left stale; every reader is masked by r_res.
            r_res <= '0;
            r_occ <= '0;
        end else begin
            r_res <= {1'b0, r_res[MAX_LATENCY-1:1]};
            for (int i = 0; i < MAX_LATENCY - 1; i++) begin
                r_tag[i] <= r_tag[i+1];
            end
            r_tag[MAX_LATENCY-1] <= '0;
            // The new reservation overrides the shifted value at slot L. That
            // value is known to be 0, because the conflict check passed.
            if (w_accept) begin
                r_res[issue_latency_i] <= 1'b1;
                r_tag[issue_latency_i] <= issue_tag_i;
            end
            r_occ <= r_occ + OW'(w_accept) - OW'(r_res[0]);
        end
    end

    // Bookkeeping sanity: a writeback with nothing outstanding is an underflow,
    // and the counter may never pass the slot budget.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            assert (!(r_res[0] && (r_occ == '0)));
            assert (r_occ <= SLOTS_MAX);
        end
    end

    assign complete_valid_o = r_res[0];
    assign complete_tag_o   = r_tag[0];
    assign occupancy_o      = r_occ;

endmodule

// File: tb/tb_multi_latency_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multi_latency_control_unit
//
// Directed bench for multi_latency_control_unit with the default parameters
// MAX_LATENCY=32, NUM_SLOTS=4 and TAG_WIDTH=4. Inputs change 1 time unit
// after the rising edge. Checks run 1 time unit later, so registered outputs
// show the previous edge and halt_pipeline_o shows the inputs just driven.
// Cycle numbers in the comments count from the start of each scenario (C0).
// -----------------------------------------------------------------------------
module tb_multi_latency_control_unit;

    localparam int MAX_LATENCY = 32;
    localparam int NUM_SLOTS   = 4;
    localparam int TAG_WIDTH   = 4;
    localparam int LW          = $clog2(MAX_LATENCY);
    localparam int OW          = $clog2(NUM_SLOTS) + 1;

    // ---------------- clock / reset ----------------
    logic clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    logic                 reset_i;
    logic                 flush_i;
    logic                 issue_valid_i;
    logic [LW-1:0]        issue_latency_i;
    logic [TAG_WIDTH-1:0] issue_tag_i;
    logic                 halt_pipeline_o;
    logic                 complete_valid_o;
    logic [TAG_WIDTH-1:0] complete_tag_o;
    logic [OW-1:0]        occupancy_o;

    multi_latency_control_unit #(
        .MAX_LATENCY (MAX_LATENCY),
        .NUM_SLOTS   (NUM_SLOTS),
        .TAG_WIDTH   (TAG_WIDTH)
    ) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_latency_i  (issue_latency_i),
        .issue_tag_i      (issue_tag_i),
        .halt_pipeline_o  (halt_pipeline_o),
        .complete_valid_o (complete_valid_o),
        .complete_tag_o   (complete_tag_o),
        .occupancy_o      (occupancy_o)
    );

    // ---------------- scoreboard state ----------------
    int                   n_checks = 0;
    int                   n_fail   = 0;
    logic [TAG_WIDTH-1:0] exp_q[$];
    int                   cyc_q[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    // Registered outputs; the tag only matters when a completion is expected.
    task automatic check_out(input string name, input logic exp_cv, input int exp_tag, input int exp_occ);
        check({name, "_cv"}, 32'(complete_valid_o), 32'(exp_cv));
        check({name, "_occ"}, 32'(occupancy_o), 32'(exp_occ));
        if (exp_cv) check({name, "_tag"}, 32'(complete_tag_o), 32'(exp_tag));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic v, input int lat, input int tag, input logic fl);
        issue_valid_i   = v;
        issue_latency_i = lat[LW-1:0];
        issue_tag_i     = tag[TAG_WIDTH-1:0];
        flush_i         = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic pending;

        // Reset held for two edges; a request during reset is not halted.
        reset_i = 1'b1;
        idle();
        tick();
        tick();
        drive(1'b1, 5, 3, 1'b0);
        check("rst_halt", 32'(halt_pipeline_o), 32'd0);
        check_out("rst", 1'b0, 0, 0);
        check("rst_tag", 32'(complete_tag_o), 32'd0);
        reset_i = 1'b0;
        idle();
        for (int c = 0; c < 10; c++) begin
            tick();
            check_out("idle", 1'b0, 0, 0);
            check("idle_halt", 32'(halt_pipeline_o), 32'd0);
        end

        // Single issue: L=5 tag 3 at C0 completes in C6 only; occupancy 1 in C1..C6.
        drive(1'b1, 5, 3, 1'b0);
        check("single_halt", 32'(halt_pipeline_o), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            idle();
            check_out("single", c == 6, 3, (c <= 6) ? 1 : 0);
        end

        // Collision: L=6 at C0; L=5 at C1 lands on the same writeback cycle.
        drive(1'b1, 6, 1, 1'b0);
        check("coll_first_halt", 32'(halt_pipeline_o), 32'd0);
        tick();
        drive(1'b1, 5, 2, 1'b0);
        check("coll_halt", 32'(halt_pipeline_o), 32'd1);
        check("coll_occ_c1", 32'(occupancy_o), 32'd1);
        tick();
        drive(1'b1, 5, 2, 1'b0);
        check("coll_retry_halt", 32'(halt_pipeline_o), 32'd0);
        check("coll_occ_c2", 32'(occupancy_o), 32'd1);
        tick();
        idle();
        check("coll_occ_c3", 32'(occupancy_o), 32'd2);
        for (int c = 4; c <= 10; c++) begin
            tick();
            idle();
            check_out("coll", (c == 7) || (c == 8), (c == 7) ? 1 : 2,
                      (c <= 7) ? 2 : ((c == 8) ? 1 : 0));
        end

        // Slot budget: four L=20 issues in C0..C3 (writebacks C21..C24).
        // A fifth request halts until the first completion cycle (C21).
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 20, 4 + c, 1'b0);
            check("full_fill_halt", 32'(halt_pipeline_o), 32'd0);
            tick();
        end
        drive(1'b1, 20, 8, 1'b0);
        for (int c = 4; c <= 21; c++) begin
            check("full_halt", 32'(halt_pipeline_o), (c < 21) ? 32'd1 : 32'd0);
            check_out("full_hold", c == 21, 4, 4);
            tick();
        end
        idle();
        check_out("full_c22", 1'b1, 5, 4);
        for (int c = 23; c <= 43; c++) begin
            tick();
            check_out("full_drain", (c == 23) || (c == 24) || (c == 42),
                      (c == 23) ? 6 : ((c == 24) ? 7 : 8),
                      (c == 23) ? 3 : ((c == 24) ? 2 : ((c <= 42) ? 1 : 0)));
        end

        // Flush: three operations in flight, flushed at C8 together with a
        // request that must be neither halted nor accepted.
        tick();
        drive(1'b1, 10, 9, 1'b0);
        check("flush_i0_halt", 32'(halt_pipeline_o), 32'd0);
        tick();
        drive(1'b1, 12, 10, 1'b0);
        check("flush_i1_halt", 32'(halt_pipeline_o), 32'd0);
        tick();
        drive(1'b1, 14, 11, 1'b0);
        check("flush_i2_halt", 32'(halt_pipeline_o), 32'd0);
        tick();
        for (int c = 3; c <= 7; c++) begin
            idle();
            check_out("flush_pre", 1'b0, 0, 3);
            tick();
        end
        drive(1'b1, 3, 12, 1'b1);
        check("flush_halt", 32'(halt_pipeline_o), 32'd0);
        check_out("flush_c8", 1'b0, 0, 3);
        tick();
        idle();
        for (int c = 9; c <= 25; c++) begin
            check_out("flush_post", 1'b0, 0, 0);
            tick();
        end

        // Reset mid-operation drops the in-flight operation silently.
        drive(1'b1, 3, 15, 1'b0);
        check("rstmid_halt", 32'(halt_pipeline_o), 32'd0);
        tick();
        idle();
        check("rstmid_occ_c1", 32'(occupancy_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            check_out("rstmid_post", 1'b0, 0, 0);
            tick();
        end

        // Completion order: L=10 tag 1 at C0, then L=2 tag 2 from C1.
        drive(1'b1, 10, 1, 1'b0);
        check("order_first_halt", 32'(halt_pipeline_o), 32'd0);
        tick();
        drive(1'b1, 2, 2, 1'b0);
`ifdef LAGARTO_V_IN_ORDER_COMPLETION_EN
        check("order_halt", 32'(halt_pipeline_o), 32'd1);
        exp_q.push_back(4'd1); cyc_q.push_back(11);
        exp_q.push_back(4'd2); cyc_q.push_back(12);
`else
        check("order_halt", 32'(halt_pipeline_o), 32'd0);
        exp_q.push_back(4'd2); cyc_q.push_back(4);
        exp_q.push_back(4'd1); cyc_q.push_back(11);
`endif
        pending = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            if (complete_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("order_extra_cv", 32'(complete_valid_o), 32'd0);
                end else begin
                    check("order_tag", 32'(complete_tag_o), 32'(exp_q.pop_front()));
                    check("order_cycle", 32'(c), 32'(cyc_q.pop_front()));
                end
            end
            if (pending && !halt_pipeline_o) pending = 1'b0;
            tick();
            if (!pending) idle();
        end
        check("order_drain", 32'(exp_q.size()), 32'd0);
        check("order_accepted", 32'(pending), 32'd0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
